// File: rtl/parity_fold_sched_if.sv
// Handshake bundle for parity_fold_sched.
//   A_*/B_* : requester channels (VALID/DATA in, READY out of the scheduler)
//   O_*     : result channel (VALID/PAR/SRC out of the scheduler, READY in)
// master: requester/consumer side. slave: the scheduler.
interface parity_fold_sched_if #(
    parameter int unsigned W = 16
);
    logic         A_VALID;
    logic         A_READY;
    logic [W-1:0] A_DATA;
    logic         B_VALID;
    logic         B_READY;
    logic [W-1:0] B_DATA;
    logic         O_VALID;
    logic         O_READY;
    logic         O_PAR;
    logic         O_SRC;

    modport master (
        output A_VALID, A_DATA, B_VALID, B_DATA, O_READY,
        input  A_READY, B_READY, O_VALID, O_PAR, O_SRC
    );

    modport slave (
        input  A_VALID, A_DATA, B_VALID, B_DATA, O_READY,
        output A_READY, B_READY, O_VALID, O_PAR, O_SRC
    );
endinterface

// File: rtl/parity_fold_sched.sv
// Two-requester parity scheduler. One XNOR-reduce lane (NXOr4 LUT 16'h9669) is
// time-shared between requesters A and B under round-robin arbitration. An
// accepted word is folded 4 bits per cycle into a running accumulator and the
// result (1 = even popcount) is returned tagged with its source.
//
// Ports:
//   CLK         : clock, rising edge
//   ASYNCRESETN : asynchronous active-low reset
//   bus_io      : parity_fold_sched_if.slave (A_*, B_*, O_* channels)
//
// Build option PARITY_FOLD_X2_EN: two NXOr4 lanes fold 8 bits per cycle
// (W must then be a multiple of 8).
module parity_fold_sched #(
    parameter int unsigned W = 16
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    parity_fold_sched_if.slave    bus_io
);

`ifdef PARITY_FOLD_X2_EN
    localparam int unsigned Lanes = 2;
`else
    localparam int unsigned Lanes = 1;
`endif
    localparam int unsigned Step   = 4 * Lanes;
    localparam int unsigned Chunks = W / Step;
    localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;
    // NXOr4 truth table: bit i is 1 when i has an even number of ones.
    localparam logic [15:0] NXor4Lut = 16'h9669;

    generate
        if ((W < Step) || ((W % Step) != 0)) begin : g_bad_width
            $error("parity_fold_sched: W must be a non-zero multiple of the fold step");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StFold, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    sr_q;
    logic            acc_q;
    logic [CntW-1:0] cnt_q;
    logic            rr_q;       // 1: B was granted last, so A wins the next tie
    logic            o_valid_q;
    logic            o_par_q;
    logic            o_src_q;

    logic chunk_par;
    logic fold;
    logic idle_ok;
    logic a_ready;
    logic b_ready;

    // Odd parity of the low Step bits: inverted LUT output per lane.
    always_comb begin
        chunk_par = 1'b0;
        for (int unsigned l = 0; l < Lanes; l++) begin
            chunk_par = chunk_par ^ ~NXor4Lut[sr_q[4*l +: 4]];
        end
    end

    assign fold = acc_q ^ chunk_par;

    // READY is gated by reset so nothing is granted while ASYNCRESETN is low.
    assign idle_ok = ASYNCRESETN && (state_q == StIdle);
    assign a_ready = idle_ok && bus_io.A_VALID && (!bus_io.B_VALID || rr_q);
    assign b_ready = idle_ok && bus_io.B_VALID && (!bus_io.A_VALID || !rr_q);

    assign bus_io.A_READY = a_ready;
    assign bus_io.B_READY = b_ready;
    assign bus_io.O_VALID = o_valid_q;
    assign bus_io.O_PAR   = o_par_q;
    assign bus_io.O_SRC   = o_src_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            rr_q      <= 1'b1;
            o_valid_q <= 1'b0;
            o_par_q   <= 1'b1;
            o_src_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (a_ready || b_ready) begin
                        sr_q    <= b_ready ? bus_io.B_DATA : bus_io.A_DATA;
                        acc_q   <= 1'b0;
                        o_src_q <= b_ready;
                        cnt_q   <= CntW'(Chunks - 1);
                        rr_q    <= b_ready;
                        state_q <= StFold;
                    end
                end
                StFold: begin
                    acc_q <= fold;
                    sr_q  <= sr_q >> Step;
                    if (cnt_q == '0) begin
                        o_par_q   <= ~fold;
                        o_valid_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (bus_io.O_READY) begin
                        o_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_fold_sched.sv
// Bench for parity_fold_sched: directed steps plus randomized words, checked
// against a transaction-level model (parity = XNOR-reduce of the whole word,
// round-robin on ties, one word in flight, fixed latency).
module tb_parity_fold_sched;
    localparam int unsigned W = 16;
`ifdef PARITY_FOLD_X2_EN
    localparam int Lat = W / 8;
`else
    localparam int Lat = W / 4;
`endif

    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b0;

    parity_fold_sched_if #(.W(W)) bus ();

    parity_fold_sched #(.W(W)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .bus_io     (bus)
    );

    always #5 CLK = ~CLK;

    int npass = 0;
    int ntot  = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           acc_hist[$];
    bit           src_hist[$];
    bit           busy = 1'b0;
    bit           last_b = 1'b1;
    int           cyc = 0;
    int           acc_edge = 0;
    logic [W-1:0] cur_word = '0;
    bit           cur_src = 1'b0;
    int           ordy_mode = 0;
    int           nresults = 0;
    logic         a_acc, b_acc, o_hs, exp_a, exp_b, exp_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive, check combinational/registered outputs, advance model.
    task automatic step();
        bus.A_VALID = (qa.size() > 0);
        bus.A_DATA  = (qa.size() > 0) ? qa[0] : W'($urandom);
        bus.B_VALID = (qb.size() > 0);
        bus.B_DATA  = (qb.size() > 0) ? qb[0] : W'($urandom);
        case (ordy_mode)
            0:       bus.O_READY = 1'b1;
            1:       bus.O_READY = 1'($urandom_range(0, 1));
            default: bus.O_READY = 1'b0;
        endcase
        #1;
        a_acc  = bus.A_VALID && bus.A_READY;
        b_acc  = bus.B_VALID && bus.B_READY;
        exp_a  = !busy && bus.A_VALID && (!bus.B_VALID || last_b);
        exp_b  = !busy && bus.B_VALID && (!bus.A_VALID || !last_b);
        exp_ov = busy && (cyc >= acc_edge + Lat);
        chk("a_ready", bus.A_READY, exp_a);
        chk("b_ready", bus.B_READY, exp_b);
        chk("o_valid", bus.O_VALID, exp_ov);
        if (exp_ov) begin
            chk("o_par", bus.O_PAR, ~^cur_word);
            chk("o_src", bus.O_SRC, cur_src);
        end
        o_hs = exp_ov && bus.O_READY;
        @(posedge CLK);
        cyc++;
        if (o_hs) begin
            busy = 1'b0;
            nresults++;
        end
        if (a_acc || b_acc) begin
            busy     = 1'b1;
            acc_edge = cyc;
            cur_src  = b_acc;
            cur_word = b_acc ? qb.pop_front() : qa.pop_front();
            last_b   = b_acc;
            acc_hist.push_back(cyc);
            src_hist.push_back(b_acc);
        end
        @(negedge CLK);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || busy) && n < max) begin
            step();
            n++;
        end
        chk("drain_bound", (qa.size() > 0 || qb.size() > 0 || busy), 1'b0);
    endtask

    initial begin
        int n;
        int r0;
        bus.A_VALID = 1'b1;
        bus.B_VALID = 1'b1;
        bus.A_DATA  = '0;
        bus.B_DATA  = '0;
        bus.O_READY = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_o_valid", bus.O_VALID, 1'b0);
        chk("rst_o_par", bus.O_PAR, 1'b1);
        chk("rst_o_src", bus.O_SRC, 1'b0);
        chk("rst_a_ready", bus.A_READY, 1'b0);
        chk("rst_b_ready", bus.B_READY, 1'b0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // Tie right after reset: A first, then B.
        qa.push_back(16'h0001);
        qb.push_back(16'hFFFF);
        src_hist.delete();
        drain(50);
        chk("t1_results", nresults, 2);
        chk("t1_first_src", (src_hist.size() > 0) ? src_hist[0] : 1'b1, 1'b0);

        // A alone, back-to-back: fixed initiation interval.
        qa.push_back(16'h9669);
        qa.push_back(16'h0007);
        qa.push_back(16'h0000);
        acc_hist.delete();
        drain(60);
        chk("t2_accepts", acc_hist.size(), 3);
        for (int i = 1; i < acc_hist.size(); i++) begin
            chk("t2_ii", acc_hist[i] - acc_hist[i-1], Lat + 2);
        end

        // Both continuously valid: grants alternate.
        for (int i = 0; i < 3; i++) begin
            qa.push_back(W'($urandom));
            qb.push_back(W'($urandom));
        end
        src_hist.delete();
        drain(100);
        chk("t3_accepts", src_hist.size(), 6);
        for (int i = 1; i < src_hist.size(); i++) begin
            chk("t3_alternate", src_hist[i] ^ src_hist[i-1], 1'b1);
        end

        // Back-pressure: result held for 10 cycles, nothing accepted.
        ordy_mode = 2;
        qa.push_back(W'($urandom));
        qb.push_back(W'($urandom));
        n = 0;
        while (!bus.O_VALID && n < 20) begin
            step();
            n++;
        end
        chk("t4_o_valid_seen", bus.O_VALID, 1'b1);
        repeat (10) step();
        ordy_mode = 0;
        drain(50);

        // Reset during the 2nd fold cycle aborts the word.
        r0 = nresults;
        qa.push_back(16'h0001);
        n = 0;
        while (!busy && n < 10) begin
            step();
            n++;
        end
        chk("t5_accepted", busy, 1'b1);
        step();
        ASYNCRESETN = 1'b0;
        #1;
        chk("t5_rst_o_valid", bus.O_VALID, 1'b0);
        chk("t5_rst_o_par", bus.O_PAR, 1'b1);
        chk("t5_rst_a_ready", bus.A_READY, 1'b0);
        qa.delete();
        busy   = 1'b0;
        last_b = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        qa.push_back(16'h0003);
        drain(50);
        chk("t5_results", nresults - r0, 1);

        // Single high bit, then a randomized mix with random back-pressure.
        qa.push_back(16'h8000);
        drain(50);
        ordy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) qa.push_back(W'($urandom));
            else qb.push_back(W'($urandom));
        end
        drain(5000);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", npass, ntot);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/parity_fold_sched.md
Name: parity_fold_sched

Overview:
- Two-requester scheduler that time-shares one 4-input XNOR-reduce lane (NXOr4 LUT, 16'h9669) to compute the parity of W-bit words.
- Round-robin arbitration between ports A and B; accepts one word, folds it 4 bits per cycle into a running accumulator, and returns the result on a valid/ready output channel tagged with its source.
- Sits between the packet/field checkers and the ice40 logic fabric, replacing per-requester wide reduction trees.

Parameters:
- W, 16, data width in bits; must be a multiple of 4 (a multiple of 8 when PARITY_FOLD_X2_EN is defined); minimum 4.

Ports:
- CLK  in  1  clock, all state updates on the rising edge
- ASYNCRESETN  in  1  asynchronous active-low reset
- A_VALID  in  1  requester A has a word
- A_READY  out  1  word A accepted this cycle
- A_DATA  in  W  requester A word
- B_VALID  in  1  requester B has a word
- B_READY  out  1  word B accepted this cycle
- B_DATA  in  W  requester B word
- O_VALID  out  1  result available
- O_READY  in  1  consumer takes the result
- O_PAR  out  1  XNOR-reduce of the accepted word: 1 when its popcount is even
- O_SRC  out  1  source of the result: 0 = A, 1 = B

Behaviour:
- Clock and reset: one clock, CLK. ASYNCRESETN is asynchronous and active-low.
- State machine: IDLE, FOLD, DONE.
- Reset values:
  - state = IDLE; accumulator = 0; chunk counter = 0.
  - RR pointer set so that A wins the next tie.
  - O_VALID = 0, O_PAR = 1, O_SRC = 0.
  - A_READY = B_READY = 0 while ASYNCRESETN is low.
- IDLE, arbitration:
  - A_READY and B_READY are combinational; only one may be high in a cycle.
  - Only A valid: A_READY = 1. Only B valid: B_READY = 1.
  - Both valid: the requester not granted last gets READY.
- IDLE, accept: on a VALID&READY edge, capture DATA into the shift register, clear the accumulator, record the source in O_SRC, set the counter to W/4-1, and go to FOLD. RR pointer updates to the winner.
- IDLE with no VALID: stay in IDLE; no state changes.
- FOLD:
  - Each cycle: acc <= acc ^ (^sr[3:0]); sr >>= 4; counter decrements.
  - On the edge where counter == 0: O_PAR <= ~(acc ^ ^sr[3:0]), O_VALID <= 1, go to DONE.
  - Both READYs are 0.
- DONE:
  - O_VALID, O_PAR and O_SRC are held stable until O_READY = 1.
  - On the O_VALID&O_READY edge: O_VALID <= 0, go to IDLE.
  - No new word is accepted in the DONE cycle itself.
- Latency: O_VALID rises W/4 edges after the accept edge (4 for W=16).
- Minimum initiation interval: W/4 + 2 cycles per word.
- Back-pressure: with O_READY held low, the result is held indefinitely and both READYs stay 0.
- Requesters must hold VALID and DATA until READY; the block samples DATA only on the accept edge.
- Reset asserted mid-FOLD or mid-DONE: the operation is aborted and the result discarded; all reset values apply immediately (async). After release, the first accept behaves as after power-up.
- W = 4 edge case: FOLD lasts exactly one cycle.

Optional Feature:
- Macro: PARITY_FOLD_X2_EN.
- Defined:
  - Two 4-bit lanes (an NXOr4x2 pair) fold 8 bits per cycle.
  - sr shifts by 8; counter is loaded with W/8-1.
  - Latency becomes W/8 (2 for W=16).
  - W must be a multiple of 8; otherwise elaboration fails through a generate-time error.
- Undefined: single lane, 4 bits per cycle, exactly as specified above.
- The output encoding, handshake and arbitration rules are the same in both builds.

Test Plan:
- Reset release, both VALID high with A_DATA=16'h0001 and B_DATA=16'hFFFF, O_READY=1.
  - A accepted first; O_VALID 4 cycles after accept with O_PAR=0, O_SRC=0.
  - Next, B accepted; O_PAR=1, O_SRC=1.
- Requester A alone streams 16'h9669, 16'h0007, 16'h0000 with O_READY=1 -> O_PAR sequence 1, 0, 1; accepts exactly 6 cycles apart.
- Both requesters continuously valid for 6 words -> grants alternate A,B,A,B,A,B; the O_SRC sequence matches.
- O_READY held low for 10 cycles after O_VALID -> O_VALID, O_PAR and O_SRC stay stable; A_READY=B_READY=0 throughout; on release the next accept occurs the cycle after the handshake.
- ASYNCRESETN pulsed low during the 2nd FOLD cycle of word 16'h0001 -> O_VALID never rises for that word; after release, the re-sent 16'h0003 yields O_PAR=1.
- With PARITY_FOLD_X2_EN defined, W=16, A_DATA=16'h8000 -> O_VALID 2 cycles after accept, O_PAR=0.
